// File: rtl/kgd2_graphics.sv
// KGD2 graphics controller: Wishbone register block, dual-port video RAM and a
// raster generator producing pixel data and sync pulses, all on wb_clk_i.
module kgd2_graphics #(
  parameter int unsigned BPP      = 1,
  parameter int unsigned SCALE    = 2,
  parameter int unsigned VRAM_AW  = 14,
  parameter int unsigned PIXDIV   = 1,
  parameter int unsigned H_TOTAL  = 1056,
  parameter int unsigned H_START  = 40,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_SYNC   = 928,
  parameter int unsigned V_TOTAL  = 628,
  parameter int unsigned V_START  = 51,
  parameter int unsigned V_ACTIVE = 572,
  parameter int unsigned V_SYNC   = 624
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [2:0]     wb_adr_i,
  input  logic [15:0]    wb_dat_i,
  output logic [15:0]    wb_dat_o,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  input  logic [1:0]     wb_sel_i,
  output logic           wb_ack_o,
  output logic [BPP-1:0] vgavideo,
  output logic           vga_hsync,
  output logic           vga_vsync,
  output logic           genable,
  output logic           tdisable
);

  localparam int unsigned PPB = 8 / BPP;
  localparam int unsigned BPL = H_ACTIVE / SCALE / PPB;
  localparam int unsigned CW  = $clog2(H_TOTAL);
  localparam int unsigned RW  = $clog2(V_TOTAL);
  localparam int unsigned IW  = $clog2(PPB);
  localparam int unsigned DW  = (PIXDIV > 1) ? $clog2(PIXDIV) : 1;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_SCAN = 2'd3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} bus_state_t;

  bus_state_t         state;
  logic               g_on, t_off, autoinc, frame_flag;
  logic [VRAM_AW-1:0] areg;
  logic [7:0]         bus_q, ras_q;
  logic [7:0]         vram [0:(2**VRAM_AW)-1];
  logic [1:0]         reg_sel;
  logic               ram_we;
  logic [15:0]        rd_data, areg_ext, areg_wr;
  logic               unused_adr0;

  logic [DW-1:0]      div;
  logic [CW-1:0]      col, hpos, xpix;
  logic [RW-1:0]      row;
  logic [VRAM_AW-1:0] line_base, fetch_addr;
  logic               sub;
  logic               tick, h_act, v_act, frame_set, vblank;
  logic [IW-1:0]      pix_idx, s1_idx;
  logic               s1_act, s1_hs, s1_vs;
  logic [7:0]         pix_shift;

  assign reg_sel     = wb_adr_i[2:1];
  assign unused_adr0 = wb_adr_i[0];
  assign genable     = g_on;
  assign tdisable    = t_off;
  assign ram_we      = (state == ST_WAIT) && wb_we_i && (reg_sel == REG_DATA) &&
                       wb_sel_i[0] && !wb_rst_i;
  assign areg_ext    = 16'(areg);
  assign areg_wr     = {wb_sel_i[1] ? wb_dat_i[15:8] : areg_ext[15:8],
                        wb_sel_i[0] ? wb_dat_i[7:0]  : areg_ext[7:0]};

  // Raster position decode for the current counters
  assign tick       = (div == DW'(PIXDIV - 1));
  assign h_act      = (32'(col) >= H_START) && (32'(col) < H_START + H_ACTIVE);
  assign v_act      = (32'(row) >= V_START) && (32'(row) < V_START + V_ACTIVE);
  assign hpos       = col - CW'(H_START);
  assign xpix       = hpos / CW'(SCALE);
  assign pix_idx    = IW'(xpix % CW'(PPB));
  assign fetch_addr = h_act ? line_base + VRAM_AW'(xpix / CW'(PPB)) : line_base;
  assign frame_set  = tick && (col == CW'(H_TOTAL - 1)) && (row == RW'(V_SYNC - 1));
  // Blanking status covers the rows after the last active line up to frame wrap
  assign vblank     = (32'(row) >= V_START + V_ACTIVE);

  always_comb begin
    rd_data = 16'h0000;
    case (reg_sel)
      REG_CSR:  rd_data = {g_on, t_off, autoinc, 11'b0, frame_flag, vblank};
      REG_DATA: rd_data = {8'h00, bus_q};
      REG_ADDR: rd_data = areg_ext;
      REG_SCAN: rd_data = 16'(fetch_addr);
      default:  rd_data = 16'h0000;
    endcase
  end

  // Bus FSM and control registers; writes become visible in the ACK cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 16'h0000;
      g_on       <= 1'b0;
      t_off      <= 1'b0;
      autoinc    <= 1'b0;
      frame_flag <= 1'b0;
      areg       <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        ST_IDLE: if (wb_cyc_i && wb_stb_i) state <= ST_WAIT;
        ST_WAIT: begin
          state    <= ST_ACK;
          wb_ack_o <= 1'b1;
          wb_dat_o <= rd_data;
          if (wb_we_i && reg_sel == REG_CSR) begin
            if (wb_sel_i[1]) {g_on, t_off, autoinc} <= wb_dat_i[15:13];
            if (wb_sel_i[0] && wb_dat_i[1]) frame_flag <= 1'b0;
          end
          if (wb_we_i && reg_sel == REG_ADDR) areg <= VRAM_AW'(areg_wr);
          if (reg_sel == REG_DATA && autoinc) areg <= areg + VRAM_AW'(1);
        end
        default: state <= ST_IDLE;
      endcase
      if (frame_set) frame_flag <= 1'b1;
    end
  end

  // Dual-port VRAM: bus read/write port and raster read port
  always_ff @(posedge wb_clk_i) begin
    if (ram_we) vram[areg] <= wb_dat_i[7:0];
    bus_q <= vram[areg];
    ras_q <= vram[fetch_addr];
  end

  always_comb pix_shift = ras_q << (BPP * 32'(s1_idx));

  // Counters, line base and the two-stage pixel/sync pipeline
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div       <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      sub       <= 1'b0;
      s1_act    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_idx    <= '0;
      vgavideo  <= '0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        if (col == CW'(H_TOTAL - 1)) begin
          col <= '0;
          if (row == RW'(V_TOTAL - 1)) begin
            row       <= '0;
            line_base <= '0;
            sub       <= 1'b0;
          end else begin
            row <= row + RW'(1);
            if (v_act) begin
              if (32'(sub) == SCALE - 1) begin
                sub       <= 1'b0;
                line_base <= line_base + VRAM_AW'(BPL);
              end else begin
                sub <= 1'b1;
              end
            end
          end
        end else begin
          col <= col + CW'(1);
        end
      end
      s1_act    <= h_act && v_act;
      s1_hs     <= (32'(col) >= H_SYNC);
      s1_vs     <= (32'(row) >= V_SYNC);
      s1_idx    <= pix_idx;
      vgavideo  <= (s1_act && g_on) ? pix_shift[7 -: BPP] : '0;
      vga_hsync <= s1_hs;
      vga_vsync <= s1_vs;
    end
  end

endmodule

// File: tb/tb_kgd2_graphics.sv
// Bench for kgd2_graphics: 1bpp and 2bpp instances on a shrunken raster, checked
// against a frame-position model every cycle plus directed bus transactions.
module tb_kgd2_graphics;

  localparam int HT = 48, HS = 4, HA = 32, HSY = 40;
  localparam int VT = 20, VS = 3, VA = 8, VSY = 16;
  localparam int SC = 2;
  localparam int FR = HT * VT;
  localparam int VDEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wb_adr = '0;
  logic [15:0] wb_dat = '0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0]  wb_sel = '0;
  logic [15:0] dat_o1, dat_o2;
  logic        ack1, ack2, hs1, hs2, vs1, vs2, gen1, gen2, tdis1, tdis2;
  logic [0:0]  vid1;
  logic [1:0]  vid2;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int last_q2;
  bit vid_chk = 1'b1;
  int tr_frame = -1;
  int hs_cnt, vs_cnt;
  int pos_q[$];
  int seq2[8];

  logic [7:0] mvram [0:VDEPTH-1];
  int m_areg = 0;
  bit m_gon = 0, m_toff = 0, m_ainc = 0;

  kgd2_graphics #(.BPP(1), .SCALE(SC), .VRAM_AW(14), .PIXDIV(1),
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .H_SYNC(HSY),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .V_SYNC(VSY)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_dat_o(dat_o1), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_sel_i(wb_sel), .wb_ack_o(ack1), .vgavideo(vid1), .vga_hsync(hs1),
    .vga_vsync(vs1), .genable(gen1), .tdisable(tdis1));

  kgd2_graphics #(.BPP(2), .SCALE(SC), .VRAM_AW(14), .PIXDIV(1),
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .H_SYNC(HSY),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .V_SYNC(VSY)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_dat_o(dat_o2), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_sel_i(wb_sel), .wb_ack_o(ack2), .vgavideo(vid2), .vga_hsync(hs2),
    .vga_vsync(vs2), .genable(gen2), .tdisable(tdis2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pixel expected at raster position (c, r), computed from frame geometry
  function automatic int exp_pix(int c, int r, int bpp);
    int ppb, bpl, x, y, b;
    if (!m_gon || c < HS || c >= HS + HA || r < VS || r >= VS + VA) return 0;
    ppb = 8 / bpp;
    bpl = HA / SC / ppb;
    x = (c - HS) / SC;
    y = (r - VS) / SC;
    b = int'(mvram[y * bpl + x / ppb]);
    return (b >> (8 - bpp * (x % ppb + 1))) & ((1 << bpp) - 1);
  endfunction

  always @(negedge clk) begin : cmp
    int n, c, r;
    if (!rst) begin
      n = cnt - 2;
      c = (n >= 0) ? n % HT : 0;
      r = (n >= 0) ? (n / HT) % VT : 0;
      chk("hsync1", int'(hs1), (c >= HSY) ? 1 : 0);
      chk("vsync1", int'(vs1), (r >= VSY) ? 1 : 0);
      chk("hsync2", int'(hs2), (c >= HSY) ? 1 : 0);
      chk("vsync2", int'(vs2), (r >= VSY) ? 1 : 0);
      if (vid_chk) begin
        chk("video1", int'(vid1), exp_pix(c, r, 1));
        chk("video2", int'(vid2), exp_pix(c, r, 2));
      end
      if (n >= 0 && n / FR == tr_frame) begin
        hs_cnt += int'(hs1);
        vs_cnt += int'(vs1);
        if (vid1 == 1'b1) pos_q.push_back(r * HT + c);
        if (r == VS && c >= HS && c < HS + 8) seq2[c - HS] = int'(vid2);
      end
    end
  end

  task automatic bus(input bit w, input int a, input int d, input int s, output int q);
    int lat;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w;
    wb_adr = 3'(a << 1); wb_dat = 16'(d); wb_sel = 2'(s);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack1 && lat < 12);
    chk("ack_latency", lat, 2);
    chk("ack_dut2", int'(ack2), 1);
    q = int'(dat_o1);
    last_q2 = int'(dat_o2);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("ack_single", int'(ack1), 0);
  endtask

  task automatic wr(input int a, input int d, input int s);
    int q;
    bus(1'b1, a, d, s, q);
    case (a)
      0: if (s[1]) begin m_gon = d[15]; m_toff = d[14]; m_ainc = d[13]; end
      1: begin
        if (s[0]) mvram[m_areg] = 8'(d);
        if (m_ainc) m_areg = (m_areg + 1) % VDEPTH;
      end
      2: m_areg = ((s[1] ? (d & 'hFF00) : (m_areg & 'hFF00)) |
                   (s[0] ? (d & 'h00FF) : (m_areg & 'h00FF))) % VDEPTH;
      default: ;
    endcase
  endtask

  task automatic rd(input string nm, input int a, input int exp, input int mask);
    int q;
    bus(1'b0, a, 0, 0, q);
    chk(nm, q & mask, exp & mask);
    if (a != 3) chk({nm, "_dut2"}, last_q2 & mask, exp & mask);
    if (a == 1 && m_ainc) m_areg = (m_areg + 1) % VDEPTH;
  endtask

  // Align to a frame start (as seen at the outputs), then trace one whole frame
  task automatic trace_frame();
    int k;
    k = 0;
    while (!(cnt >= 2 && (cnt - 2) % FR == 0) && k < 3 * FR) begin
      @(negedge clk);
      k++;
    end
    chk("frame_align_timeout", (k < 3 * FR) ? 1 : 0, 1);
    hs_cnt = 0; vs_cnt = 0;
    pos_q.delete();
    foreach (seq2[i]) seq2[i] = -1;
    vid_chk = 1'b1;
    tr_frame = (cnt - 2) / FR;
    repeat (FR + 4) @(negedge clk);
    tr_frame = -1;
  endtask

  initial begin
    int exp_pos[4];
    int exp_seq[8];
    int k;
    exp_pos = '{3 * HT + 4, 3 * HT + 5, 4 * HT + 4, 4 * HT + 5};
    exp_seq = '{2, 2, 1, 1, 0, 0, 3, 3};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd("scan_reset", 3, 0, 'hFFFF);
    rd("csr_reset", 0, 0, 'hFFFF);
    rd("addr_reset", 2, 0, 'hFFFF);
    chk("genable_reset", int'(gen1), 0);
    chk("tdisable_reset", int'(tdis1), 0);

    // Auto-increment with wrap at the top of VRAM
    wr(2, 'h3FFF, 3);
    wr(0, 'h2000, 3);
    wr(1, 'h00A5, 1);
    wr(1, 'h005A, 1);
    rd("addr_after_wrap", 2, 'h0001, 'hFFFF);
    wr(2, 'h3FFF, 3);
    rd("data_top", 1, 'h00A5, 'hFFFF);
    rd("data_wrapped", 1, 'h005A, 'hFFFF);
    rd("addr_after_reads", 2, 'h0001, 'hFFFF);

    // Clear the displayed area, place one byte, turn graphics on
    wr(2, 0, 3);
    repeat (16) wr(1, 0, 1);
    wr(2, 0, 3);
    wr(1, 'h80, 1);
    vid_chk = 1'b0;
    wr(0, 'hA000, 3);
    chk("genable_on", int'(gen1), 1);
    chk("tdisable_off", int'(tdis1), 0);
    chk("genable_on_dut2", int'(gen2), 1);
    trace_frame();
    chk("video1_pixels", pos_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("video1_position", (i < pos_q.size()) ? pos_q[i] : -1, exp_pos[i]);
    chk("hsync_cycles", hs_cnt, 8 * VT);
    chk("vsync_cycles", vs_cnt, 4 * HT);

    // Frame flag and vblank, read inside row 13 (post-active blanking)
    k = 0;
    while (cnt % FR != 13 * HT && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    chk("row13_timeout", (k < 2 * FR) ? 1 : 0, 1);
    rd("csr_flag_set", 0, 'hA003, 'hFFFF);
    wr(0, 'hA002, 3);
    rd("csr_flag_clear", 0, 'hA001, 'hFFFF);

    // 2bpp pixel order
    vid_chk = 1'b0;
    wr(2, 0, 3);
    wr(1, 'h93, 1);
    trace_frame();
    for (int i = 0; i < 8; i++) chk("video2_sequence", seq2[i], exp_seq[i]);

    // Reset during the WAIT state of a DATA write
    wr(2, 5, 3);
    vid_chk = 1'b0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 3'b010; wb_dat = 16'h0077; wb_sel = 2'b11;
    @(negedge clk);
    chk("rst_wait_no_ack", int'(ack1), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_ack", int'(ack1), 0);
    rst = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    m_gon = 0; m_toff = 0; m_ainc = 0; m_areg = 0;
    @(negedge clk);
    chk("post_rst_no_ack", int'(ack1), 0);
    vid_chk = 1'b1;
    rd("csr_after_rst", 0, 0, 'hFFFE);
    rd("addr_after_rst", 2, 0, 'hFFFF);
    chk("genable_after_rst", int'(gen1), 0);
    wr(2, 5, 3);
    rd("vram_kept", 1, 'h0000, 'hFFFF);
    wr(1, 'h3C, 1);
    rd("vram_new_write", 1, 'h003C, 'hFFFF);
    rd("addr_no_autoinc", 2, 'h0005, 'hFFFF);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
